// File: rtl/decoder_pkg.sv
// Shared FSM state encoding and mode constants for the decoder_scan slice.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_dwell_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while run is high, tick marks the last cycle.
module decoder_dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam logic [15:0] TC = 16'(DWELL - 1);

  logic [15:0] cnt;

  assign tick = run & ~clr & (cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// One-hot decoder with direct select and optional auto-scan.
// Scan mode, dwell timer and wrap pulse exist only when DECODER_SCAN_AUTO_EN is defined.
//
//   state  | meaning
//   IDLE   | en low: out forced to zero, idx held
//   DIRECT | out follows accepted sel, otherwise holds
//   SCAN   | idx advances every DWELL cycles, wrap on OUT_W-1 -> 0
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W = 3,
  parameter  int DWELL = 4,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  output logic             sel_ready,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  state_t           state;
  logic             mode_eff;
  logic             accept;
  logic             step;
  logic [SEL_W-1:0] idx_inc;

  function automatic logic [OUT_W-1:0] dec(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef DECODER_SCAN_AUTO_EN
  logic run;
  logic wrap_q;

  assign mode_eff = mode;
  // Counter only runs once SCAN has been entered, so the first step lands DWELL cycles after entry.
  assign run      = en & (mode == MODE_SCAN) & (state == SCAN);

  decoder_dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (~run),
    .run  (run),
    .tick (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= step & (&idx);
    end
  end

  assign wrap = wrap_q;
`else
  logic     unused_mode;
  logic     unused_state;
  localparam int unused_dwell = DWELL;

  assign mode_eff     = MODE_DIRECT;
  assign step         = 1'b0;
  assign wrap         = 1'b0;
  assign unused_mode  = mode;
  assign unused_state = ^state;
`endif

  assign sel_ready = en & (mode_eff == MODE_DIRECT);
  assign accept    = sel_valid & sel_ready;
  assign idx_inc   = idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= '0;
      idx   <= '0;
    end else if (!en) begin
      state <= IDLE;
      out   <= '0;
    end else begin
      state <= (mode_eff == MODE_SCAN) ? SCAN : DIRECT;
      if (accept) begin
        idx <= sel;
        out <= dec(sel);
      end else if (step) begin
        idx <= idx_inc;
        out <= dec(idx_inc);
      end else begin
        out <= dec(idx);
      end
    end
  end

endmodule
